// File: rtl/entradas_usuario_pkg.sv
// entradas_pkg: shared definitions for the entradas_usuario user-input peripheral.
//   - dir_t      : 2-bit word select on the register bus
//   - DIR_*      : register map word addresses
//   - DATA_W     : width of the read/write data bus
//   - flags_next : sticky-flag update rule (W1C with set priority)
package entradas_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_SW    = 2'd0;
    localparam dir_t DIR_BTN   = 2'd1;
    localparam dir_t DIR_FLAGS = 2'd2;
    localparam dir_t DIR_MASK  = 2'd3;

    localparam int DATA_W = 32;

    // Clear first, then OR in new events, so a rise that lands in the same
    // cycle as its own clear survives.
    function automatic logic [DATA_W-1:0] flags_next(input logic [DATA_W-1:0] cur,
                                                     input logic [DATA_W-1:0] set,
                                                     input logic [DATA_W-1:0] clr);
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/entradas_usuario_if.sv
// entradas_usuario_if: register bus between the core load/store path and the
// user-input peripheral.
//   addr_i  : word select (see entradas_pkg DIR_*)
//   we_i    : write strobe
//   wdata_i : write data
//   rdata_o : registered read data (1-cycle latency)
//   irq_o   : registered level interrupt
// master = core side, slave = peripheral side.
interface entradas_usuario_if;
    entradas_pkg::dir_t        addr_i;
    logic                      we_i;
    logic [31:0]               wdata_i;
    logic [31:0]               rdata_o;
    logic                      irq_o;

    modport master (
        output addr_i, we_i, wdata_i,
        input  rdata_o, irq_o
    );

    modport slave (
        input  addr_i, we_i, wdata_i,
        output rdata_o, irq_o
    );
endinterface

// File: rtl/entradas_usuario_antirrebote.sv
// antirrebote: one button input -> 2-FF synchroniser -> optional debounce.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   pin_i          : raw asynchronous pin
//   level_o        : accepted (stable) level
// Optional feature macro: ENTRADAS_DEBOUNCE_EN. When defined, the level only
// follows the synchronised pin after DEB_CYCLES consecutive mismatching cycles;
// otherwise the level is the synchroniser output.
module antirrebote #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
        end
    end

`ifdef ENTRADAS_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("antirrebote: DEB_CYCLES must be >= 1");
    end

    // Counter runs only while the input disagrees with the accepted level;
    // any agreement restarts it, so short glitches never accumulate.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                lvl_d = ~lvl_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign level_o = lvl_q;
`else
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("antirrebote: DEB_CYCLES must be >= 1");
    end

    assign level_o = s2_q;
`endif

endmodule

// File: rtl/entradas_usuario.sv
// entradas_usuario: memory-mapped switches/buttons peripheral.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   switches_i     : N_SW raw switch pins (2-FF synchronised, read at DIR_SW)
//   botones_i      : N_BTN raw button pins (antirrebote per bit, read at DIR_BTN)
//   bus            : entradas_usuario_if.slave register port
// Register map: 0 SW (RO), 1 BTN (RO), 2 FLAGS (sticky rise flags, W1C),
// 3 IRQ_MASK (RW). irq_o = registered |(FLAGS & IRQ_MASK).
// Optional feature macro: ENTRADAS_DEBOUNCE_EN (button debounce, see antirrebote).
module entradas_usuario
    import entradas_pkg::*;
#(
    parameter int N_SW       = 16,
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SW-1:0]  switches_i,
    input  logic [N_BTN-1:0] botones_i,
    entradas_usuario_if.slave bus
);

    if (N_SW < 1 || N_SW > 32) begin : g_bad_nsw
        $error("entradas_usuario: N_SW must be in 1..32");
    end
    if (N_BTN < 1 || N_BTN > 32) begin : g_bad_nbtn
        $error("entradas_usuario: N_BTN must be in 1..32");
    end

    // ---------------- switches ----------------
    logic [N_SW-1:0] sw_s1_q, sw_s2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= switches_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    // ---------------- buttons ----------------
    logic [N_BTN-1:0] lvl;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_ar (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .pin_i   (botones_i[i]),
            .level_o (lvl[i])
        );
    end

    // ---------------- flags / mask ----------------
    logic [N_BTN-1:0] prev_q;
    logic [N_BTN-1:0] flags_q, flags_d;
    logic [N_BTN-1:0] mask_q, mask_d;
    logic [N_BTN-1:0] rise, clr;
    logic             wr_flags, wr_mask;
    logic [31:0]      flags_full;

    assign wr_flags = bus.we_i && (bus.addr_i == DIR_FLAGS);
    assign wr_mask  = bus.we_i && (bus.addr_i == DIR_MASK);
    assign rise     = lvl & ~prev_q;
    assign clr      = wr_flags ? bus.wdata_i[N_BTN-1:0] : '0;

    assign flags_full = flags_next(32'(flags_q), 32'(rise), 32'(clr));
    assign flags_d    = flags_full[N_BTN-1:0];
    assign mask_d     = wr_mask ? bus.wdata_i[N_BTN-1:0] : mask_q;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^{bus.wdata_i, flags_full};

    // ---------------- read port / irq ----------------
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    always_comb begin
        rdata_d = '0;
        unique case (bus.addr_i)
            DIR_SW:    rdata_d = 32'(sw_s2_q);
            DIR_BTN:   rdata_d = 32'(lvl);
            DIR_FLAGS: rdata_d = 32'(flags_q);
            DIR_MASK:  rdata_d = 32'(mask_q);
            default:   rdata_d = '0;
        endcase
    end

    assign irq_d = |(flags_q & mask_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q  <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev_q  <= lvl;
            flags_q <= flags_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.irq_o   = irq_q;

endmodule
